// File: rtl/timer_digit_entry.sv
// timer_digit_entry: keypad digit collector that loads MM:SS BCD into the timer counter chain
// Inputs: clk, clr (sync reset), key_valid/key_code (keystroke), start, cancel, timer_zero (chain at 00:00)
// Outputs: sec_u/sec_t/min_u/min_t (BCD load data), loadn (load strobe), running, err (rejected start), ndigits
module timer_digit_entry #(
  parameter int MAX_DIGITS = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       start,
  input  logic       cancel,
  input  logic       timer_zero,
  output logic [3:0] sec_u,
  output logic [3:0] sec_t,
  output logic [3:0] min_u,
  output logic [3:0] min_t,
  output logic       loadn,
  output logic       running,
  output logic       err,
  output logic [2:0] ndigits
);
  typedef enum logic [1:0] {IDLE, ENTRY, LOAD, RUN} state_t;
  localparam logic [2:0] MAXN = 3'(MAX_DIGITS);
  state_t state;
  logic armed;
  logic wipe;
  logic nonzero;
  logic key_ok;
  // armed masks timer_zero in the first RUN cycle, while the counters may still show the pre-load value
  assign wipe = cancel || (state == RUN && armed && timer_zero);
  assign nonzero = |{min_t, min_u, sec_t, sec_u};
  assign key_ok = key_valid && key_code <= 4'd9 && ndigits < MAXN;
  always_ff @(posedge clk) begin
    if (clr || wipe) begin
      state <= IDLE;
      sec_u <= '0;
      sec_t <= '0;
      min_u <= '0;
      min_t <= '0;
      ndigits <= '0;
      loadn <= 1'b1;
      running <= 1'b0;
      err <= 1'b0;
      armed <= 1'b0;
    end else begin
      err <= 1'b0;
      loadn <= 1'b1;
      case (state)
        IDLE, ENTRY: begin
          if (start) begin
            if (nonzero && sec_t > 4'd5) err <= 1'b1;
            else if (nonzero) begin
              state <= LOAD;
              loadn <= 1'b0;
            end
          end else if (key_ok) begin
            min_t <= min_u;
            min_u <= sec_t;
            sec_t <= sec_u;
            sec_u <= key_code;
            ndigits <= ndigits + 3'd1;
            state <= ENTRY;
          end
        end
        LOAD: begin
          state <= RUN;
          running <= 1'b1;
          armed <= 1'b0;
        end
        RUN: armed <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_timer_digit_entry.sv
// tb_timer_digit_entry: table, directed and randomized checks of timer_digit_entry against a queue-based model
module tb_timer_digit_entry;
  logic clk = 1'b0;
  logic clr = 1'b0, key_valid = 1'b0, start = 1'b0, cancel = 1'b0, timer_zero = 1'b0;
  logic [3:0] key_code = '0;
  logic [3:0] sec_u, sec_t, min_u, min_t;
  logic loadn, running, err;
  logic [2:0] ndigits;
  int nvec = 0;
  int nbad = 0;
  int q[$];
  int phase = 0;
  int run_cycles = 0;
  bit m_err = 1'b0;
  bit m_loadn = 1'b1;
  typedef struct {
    bit kv;
    logic [3:0] kc;
    bit st, cn, tz, cl;
    logic [15:0] bus;
    bit ld, run, er;
    logic [2:0] nd;
  } vec_t;
  vec_t tbl[$];
  always #5 clk = ~clk;
  timer_digit_entry dut (
    .clk(clk), .clr(clr), .key_valid(key_valid), .key_code(key_code), .start(start),
    .cancel(cancel), .timer_zero(timer_zero), .sec_u(sec_u), .sec_t(sec_t), .min_u(min_u),
    .min_t(min_t), .loadn(loadn), .running(running), .err(err), .ndigits(ndigits)
  );
  function automatic int dg(int i);
    return q.size() > i ? q[q.size() - 1 - i] : 0;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_step(bit kv, int kc, bit st, bit cn, bit tz, bit cl);
    m_err = 1'b0;
    m_loadn = 1'b1;
    if (cl || cn) begin
      q.delete();
      phase = 0;
    end else if (phase == 0) begin
      if (st) begin
        if (dg(3) * 1000 + dg(2) * 100 + dg(1) * 10 + dg(0) == 0) ;
        else if (dg(1) > 5) m_err = 1'b1;
        else begin
          phase = 1;
          m_loadn = 1'b0;
        end
      end else if (kv && kc <= 9 && q.size() < 4) q.push_back(kc);
    end else if (phase == 1) begin
      phase = 2;
      run_cycles = 0;
    end else if (run_cycles >= 1 && tz) begin
      q.delete();
      phase = 0;
    end else run_cycles++;
  endtask
  task automatic cyc(bit kv, int kc, bit st, bit cn, bit tz, bit cl);
    @(negedge clk);
    key_valid = kv;
    key_code = 4'(kc);
    start = st;
    cancel = cn;
    timer_zero = tz;
    clr = cl;
    @(posedge clk);
    #1;
    model_step(kv, kc, st, cn, tz, cl);
    chk("model bus", {min_t, min_u, sec_t, sec_u}, 32'(dg(3) << 12 | dg(2) << 8 | dg(1) << 4 | dg(0)));
    chk("model loadn", 32'(loadn), 32'(m_loadn));
    chk("model running", 32'(running), 32'(phase == 2));
    chk("model err", 32'(err), 32'(m_err));
    chk("model ndigits", 32'(ndigits), 32'(q.size()));
  endtask
  initial begin
    tbl.push_back('{0, 0, 0, 0, 0, 1, 16'h0000, 1, 0, 0, 0});
    tbl.push_back('{1, 1, 0, 0, 0, 0, 16'h0001, 1, 0, 0, 1});
    tbl.push_back('{1, 3, 0, 0, 0, 0, 16'h0013, 1, 0, 0, 2});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 16'h0130, 1, 0, 0, 3});
    tbl.push_back('{0, 0, 1, 0, 0, 0, 16'h0130, 0, 0, 0, 3});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 16'h0130, 1, 1, 0, 3});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 16'h0130, 1, 1, 0, 3});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 16'h0130, 1, 1, 0, 3});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 16'h0130, 1, 1, 0, 3});
    tbl.push_back('{0, 0, 0, 0, 1, 0, 16'h0000, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 0, 0, 16'h0000, 1, 0, 0, 0});
    tbl.push_back('{1, 12, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 0});
    tbl.push_back('{1, 12, 1, 0, 0, 0, 16'h0000, 1, 0, 0, 0});
    tbl.push_back('{1, 4, 0, 0, 0, 0, 16'h0004, 1, 0, 0, 1});
    tbl.push_back('{1, 5, 1, 0, 0, 0, 16'h0004, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 16'h0004, 1, 1, 0, 1});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 16'h0000, 1, 0, 0, 0});
    tbl.push_back('{1, 7, 0, 0, 0, 0, 16'h0007, 1, 0, 0, 1});
    tbl.push_back('{0, 0, 1, 1, 0, 0, 16'h0000, 1, 0, 0, 0});
    tbl.push_back('{1, 8, 0, 0, 0, 0, 16'h0008, 1, 0, 0, 1});
    tbl.push_back('{1, 8, 0, 0, 0, 0, 16'h0088, 1, 0, 0, 2});
    tbl.push_back('{0, 0, 1, 0, 0, 0, 16'h0088, 1, 0, 1, 2});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 16'h0088, 1, 0, 0, 2});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 16'h0000, 1, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 1});
    tbl.push_back('{0, 0, 1, 0, 0, 0, 16'h0000, 1, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 16'h0000, 1, 0, 0, 0});
    foreach (tbl[i]) begin
      cyc(tbl[i].kv, int'(tbl[i].kc), tbl[i].st, tbl[i].cn, tbl[i].tz, tbl[i].cl);
      chk($sformatf("row%0d bus", i), {min_t, min_u, sec_t, sec_u}, 32'(tbl[i].bus));
      chk($sformatf("row%0d loadn", i), 32'(loadn), 32'(tbl[i].ld));
      chk($sformatf("row%0d running", i), 32'(running), 32'(tbl[i].run));
      chk($sformatf("row%0d err", i), 32'(err), 32'(tbl[i].er));
      chk($sformatf("row%0d ndigits", i), 32'(ndigits), 32'(tbl[i].nd));
    end
    for (int i = 0; i < 4; i++) cyc(1, 9, 0, 0, 0, 0);
    cyc(1, 7, 0, 0, 0, 0);
    chk("fifth key ndigits", 32'(ndigits), 4);
    chk("fifth key bus", {min_t, min_u, sec_t, sec_u}, 32'h9999);
    cyc(0, 0, 1, 0, 0, 0);
    chk("bad start err", 32'(err), 1);
    chk("bad start loadn", 32'(loadn), 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("err one cycle", 32'(err), 0);
    chk("digits kept", {min_t, min_u, sec_t, sec_u}, 32'h9999);
    cyc(0, 0, 0, 1, 0, 0);
    chk("cancel bus", {min_t, min_u, sec_t, sec_u}, 0);
    chk("cancel ndigits", 32'(ndigits), 0);
    cyc(1, 2, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 1, 0);
    chk("tz load", 32'(loadn), 0);
    cyc(1, 3, 0, 0, 1, 0);
    chk("tz run1", 32'(running), 1);
    cyc(1, 3, 0, 0, 1, 0);
    chk("tz run2", 32'(running), 1);
    chk("tz keys ignored", {min_t, min_u, sec_t, sec_u}, 32'h0020);
    cyc(0, 0, 0, 0, 1, 0);
    chk("tz idle", 32'(running), 0);
    chk("tz cleared", {min_t, min_u, sec_t, sec_u}, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("clr in load loadn", 32'(loadn), 1);
    chk("clr in load running", 32'(running), 0);
    chk("clr in load ndigits", 32'(ndigits), 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("no second loadn", 32'(loadn), 1);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("clr in run running", 32'(running), 0);
    chk("clr in run bus", {min_t, min_u, sec_t, sec_u}, 0);
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(1, 0) == 1, int'($urandom_range(15, 0)), $urandom_range(7, 0) == 0,
          $urandom_range(31, 0) == 0, $urandom_range(5, 0) == 0, $urandom_range(127, 0) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
